// File: rtl/regfile_sb.sv
// Register file with per-register pending (scoreboard) bits, write-first read bypass and reserve-conflict flag.
// Optional build macro REGFILE_R0_ZERO_EN hardwires register 0 to zero (never written, never reserved).
module regfile_sb #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] read_addr0,
  input  logic [ADDR_W-1:0] read_addr1,
  output logic [DATA_W-1:0] read_data0,
  output logic [DATA_W-1:0] read_data1,
  output logic              read_valid0,
  output logic              read_valid1,
  output logic              rsv_err,
  output logic [ADDR_W:0]   pending_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic              rsv_err_q, rsv_err_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              wr_act, rsv_act;
  logic              hit0, hit1;

  // With r0 hardwired, gating the strobes alone keeps mem_q[0] and pend_q[0]
  // at their reset value, so the read path needs no special case.
`ifdef REGFILE_R0_ZERO_EN
  assign wr_act  = write_enable && (write_addr != '0);
  assign rsv_act = rsv_en && (rsv_addr != '0);
`else
  assign wr_act  = write_enable;
  assign rsv_act = rsv_en;
`endif

  assign hit0 = wr_act && (read_addr0 == write_addr);
  assign hit1 = wr_act && (read_addr1 == write_addr);

  assign read_data0  = hit0 ? write_data : mem_q[read_addr0];
  assign read_data1  = hit1 ? write_data : mem_q[read_addr1];
  assign read_valid0 = hit0 | ~pend_q[read_addr0];
  assign read_valid1 = hit1 | ~pend_q[read_addr1];

  // Reserve is applied after the write so it wins on the same address.
  always_comb begin
    pend_d = pend_q;
    if (wr_act)  pend_d[write_addr] = 1'b0;
    if (rsv_act) pend_d[rsv_addr]   = 1'b1;
    rsv_err_d = rsv_act && pend_q[rsv_addr];
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_d = cnt_d + {{ADDR_W{1'b0}}, pend_d[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      pend_q    <= '0;
      rsv_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (wr_act) mem_q[write_addr] <= write_data;
      pend_q    <= pend_d;
      rsv_err_q <= rsv_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign rsv_err     = rsv_err_q;
  assign pending_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized self-checking bench for regfile_sb against an array-based reference model.
// Honours REGFILE_R0_ZERO_EN in the model when the build defines it.
module tb_regfile_sb;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int DEPTH = 1 << AW;
`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          write_enable = 1'b0;
  logic [AW-1:0] write_addr = '0;
  logic [DW-1:0] write_data = '0;
  logic          rsv_en = 1'b0;
  logic [AW-1:0] rsv_addr = '0;
  logic [AW-1:0] read_addr0 = '0;
  logic [AW-1:0] read_addr1 = '0;
  logic [DW-1:0] read_data0, read_data1;
  logic          read_valid0, read_valid1;
  logic          rsv_err;
  logic [AW:0]   pending_cnt;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .read_addr0(read_addr0), .read_addr1(read_addr1),
    .read_data0(read_data0), .read_data1(read_data1),
    .read_valid0(read_valid0), .read_valid1(read_valid1),
    .rsv_err(rsv_err), .pending_cnt(pending_cnt)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  logic [DW-1:0] m_mem [DEPTH];
  bit            m_pend [DEPTH];
  bit            m_err;

  logic [DW-1:0] cap_rd0, cap_rd1;
  logic          cap_v0, cap_v1, cap_err;
  logic [AW:0]   cap_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_cnt();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
    m_err = 1'b0;
  endfunction

  function automatic bit is_r0(input int a);
    return R0Z && (a == 0);
  endfunction

  function automatic int m_rd(input bit we, input int wa, input int wd, input int a);
    if (is_r0(a)) return 0;
    if (we && wa == a) return wd;
    return int'(m_mem[a]);
  endfunction

  function automatic bit m_valid(input bit we, input int wa, input int a);
    if (is_r0(a)) return 1'b1;
    if (we && wa == a) return 1'b1;
    return !m_pend[a];
  endfunction

  task automatic cycle(input bit we, input int wa, input int wd,
                       input bit rv, input int ra, input int a0, input int a1);
    bit old;
    @(negedge clk);
    write_enable = we; write_addr = AW'(wa); write_data = DW'(wd);
    rsv_en = rv; rsv_addr = AW'(ra);
    read_addr0 = AW'(a0); read_addr1 = AW'(a1);
    #1;
    cap_rd0 = read_data0; cap_rd1 = read_data1;
    cap_v0 = read_valid0; cap_v1 = read_valid1;
    chk("rd0", 32'(read_data0), 32'(m_rd(we, wa, wd, a0)));
    chk("rd1", 32'(read_data1), 32'(m_rd(we, wa, wd, a1)));
    chk("v0", 32'(read_valid0), 32'(m_valid(we, wa, a0)));
    chk("v1", 32'(read_valid1), 32'(m_valid(we, wa, a1)));
    @(posedge clk);
    if (rst_n) begin
      old = m_pend[ra];
      if (we && !is_r0(wa)) begin
        m_mem[wa]  = DW'(wd);
        m_pend[wa] = 1'b0;
      end
      if (rv && !is_r0(ra)) begin
        m_err = old;
        m_pend[ra] = 1'b1;
      end else begin
        m_err = 1'b0;
      end
    end
    #1;
    cap_err = rsv_err; cap_cnt = pending_cnt;
    chk("rsv_err", 32'(rsv_err), 32'(m_err));
    chk("pcnt", 32'(pending_cnt), 32'(m_cnt()));
  endtask

  // Async reset dropped between edges; outputs must clear without a clock edge.
  task automatic async_reset();
    write_enable = 1'b0; rsv_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    m_clear();
    chk("rst_cnt", 32'(pending_cnt), 32'd0);
    chk("rst_err", 32'(rsv_err), 32'd0);
    for (int a = 0; a < DEPTH; a += 2) begin
      read_addr0 = AW'(a); read_addr1 = AW'(a + 1);
      #1;
      chk("rst_rd0", 32'(read_data0), 32'd0);
      chk("rst_rd1", 32'(read_data1), 32'd0);
      chk("rst_v0", 32'(read_valid0), 32'd1);
      chk("rst_v1", 32'(read_valid1), 32'd1);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    m_clear();
    #3;
    async_reset();

    // write r3, read on both ports next cycle
    cycle(1, 3, 'hA5, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 3, 3);
    chk("r3_rd0", 32'(cap_rd0), 32'hA5);
    chk("r3_rd1", 32'(cap_rd1), 32'hA5);
    chk("r3_v0", 32'(cap_v0 & cap_v1), 32'd1);

    // same-cycle bypass
    cycle(1, 5, 'h3C, 0, 0, 5, 5);
    chk("byp_rd0", 32'(cap_rd0), 32'h3C);

    // reserve then write r2
    cycle(0, 0, 0, 1, 2, 2, 2);
    chk("rsv2_cnt", 32'(cap_cnt), 32'd1);
    cycle(0, 0, 0, 0, 0, 2, 2);
    chk("rsv2_v0", 32'(cap_v0), 32'd0);
    cycle(1, 2, 'h11, 0, 0, 2, 2);
    chk("wr2_byp_v", 32'(cap_v0), 32'd1);
    chk("wr2_cnt", 32'(cap_cnt), 32'd0);
    cycle(0, 0, 0, 0, 0, 2, 2);
    chk("wr2_rd", 32'(cap_rd0), 32'h11);
    chk("wr2_v", 32'(cap_v0), 32'd1);

    // double reserve r4
    cycle(0, 0, 0, 1, 4, 4, 0);
    chk("r4a_err", 32'(cap_err), 32'd0);
    cycle(0, 0, 0, 1, 4, 4, 0);
    chk("r4b_err", 32'(cap_err), 32'd1);
    chk("r4b_cnt", 32'(cap_cnt), 32'd1);
    cycle(0, 0, 0, 0, 0, 4, 0);
    chk("r4c_err", 32'(cap_err), 32'd0);

    // write and reserve same address: data lands, reserve wins, err from old state
    cycle(1, 4, 'h77, 1, 4, 4, 0);
    chk("wr_rsv_err", 32'(cap_err), 32'd1);
    cycle(0, 0, 0, 0, 0, 4, 4);
    chk("wr_rsv_rd", 32'(cap_rd0), 32'h77);
    chk("wr_rsv_v", 32'(cap_v0), 32'd0);

    // reserve r1, r6, r7 then reset mid-cycle
    cycle(0, 0, 0, 1, 1, 0, 0);
    cycle(0, 0, 0, 1, 6, 0, 0);
    cycle(0, 0, 0, 1, 7, 0, 0);
    async_reset();

    // writes/reserves ignored while in reset, bypass still visible
    @(negedge clk);
    rst_n = 1'b0;
    m_clear();
    cycle(1, 3, 'h5A, 1, 3, 3, 2);
    chk("inrst_cnt", 32'(cap_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    write_enable = 1'b0; rsv_en = 1'b0;
    cycle(0, 0, 0, 0, 0, 3, 3);
    chk("inrst_rd", 32'(cap_rd0), 32'd0);

    // register 0 behaviour
    cycle(1, 0, 'hFF, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0);
    chk("r0_cnt", 32'(cap_cnt), R0Z ? 32'd0 : 32'd1);
    cycle(0, 0, 0, 0, 0, 0, 0);
    chk("r0_rd", 32'(cap_rd0), R0Z ? 32'h00 : 32'hFF);
    chk("r0_v", 32'(cap_v0), R0Z ? 32'd1 : 32'd0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      cycle(bit'($urandom_range(0, 2) == 0), int'($urandom_range(0, DEPTH - 1)),
            int'($urandom_range(0, 255)), bit'($urandom_range(0, 2) == 0),
            int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)),
            int'($urandom_range(0, DEPTH - 1)));
      if ($urandom_range(0, 59) == 0) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
